// File: rtl/seq_wide_comparator_ctrl.sv
// Wide unsigned comparator that walks the operands one N-bit slice per clock,
// MSB slice first, and stops at the first unequal slice.
module seq_wide_comparator_ctrl #(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [W-1:0]             a,
  input  logic [W-1:0]             b,
  output logic                     busy,
  output logic                     done,
  output logic                     great,
  output logic                     less,
  output logic                     equal,
  output logic [$clog2(W/N):0]     slices_used
);

  localparam int S  = W / N;
  localparam int CW = $clog2(S) + 1;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(S - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r, state_n;
  logic [W-1:0]    a_r, a_n, b_r, b_n;
  logic [IW-1:0]   idx_r, idx_n;
  logic            great_r, great_n, less_r, less_n, equal_r, equal_n;
  logic            busy_r, done_r;
  logic [CW-1:0]   used_r, used_n;
  logic [N-1:0]    slice_a_s, slice_b_s;

  // Operands shift left each step, so the slice under test is always the top N bits.
  assign slice_a_s = a_r[W-1 -: N];
  assign slice_b_s = b_r[W-1 -: N];

  // Next-state and next-result logic for the IDLE/CMP/DONE sequencer.
  always_comb begin
    state_n = state_r;
    a_n     = a_r;
    b_n     = b_r;
    idx_n   = idx_r;
    great_n = great_r;
    less_n  = less_r;
    equal_n = equal_r;
    used_n  = used_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          idx_n   = {IW{1'b0}};
          great_n = 1'b0;
          less_n  = 1'b0;
          equal_n = 1'b0;
          used_n  = {CW{1'b0}};
          state_n = CMP;
        end else begin
          state_n = IDLE;
        end
      end
      CMP: begin
        if (slice_a_s > slice_b_s) begin
          great_n = 1'b1;
          used_n  = CW'(idx_r) + {{(CW-1){1'b0}}, 1'b1};
          state_n = DONE;
        end else if (slice_a_s < slice_b_s) begin
          less_n  = 1'b1;
          used_n  = CW'(idx_r) + {{(CW-1){1'b0}}, 1'b1};
          state_n = DONE;
        end else if (idx_r == LAST_IDX) begin
          equal_n = 1'b1;
          used_n  = CW'(S);
          state_n = DONE;
        end else begin
          idx_n   = idx_r + {{(IW-1){1'b0}}, 1'b1};
          a_n     = a_r << N;
          b_n     = b_r << N;
          state_n = CMP;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, operand and result registers; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      idx_r   <= {IW{1'b0}};
      great_r <= 1'b0;
      less_r  <= 1'b0;
      equal_r <= 1'b0;
      used_r  <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      a_r     <= a_n;
      b_r     <= b_n;
      idx_r   <= idx_n;
      great_r <= great_n;
      less_r  <= less_n;
      equal_r <= equal_n;
      used_r  <= used_n;
      busy_r  <= (state_n != IDLE);
      done_r  <= (state_n == DONE);
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign great       = great_r;
  assign less        = less_r;
  assign equal       = equal_r;
  assign slices_used = used_r;

endmodule

// File: tb/tb_seq_wide_comparator_ctrl.sv
// Directed and randomized checks of seq_wide_comparator_ctrl for W=16/N=4 and
// W=32/N=8 against a full-width arithmetic reference.
module tb_seq_wide_comparator_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic        start0 = 1'b0;
  logic [15:0] a0 = 16'h0, b0 = 16'h0;
  logic        busy0, done0, great0, less0, equal0;
  logic [2:0]  used0;

  logic        start1 = 1'b0;
  logic [31:0] a1 = 32'h0, b1 = 32'h0;
  logic        busy1, done1, great1, less1, equal1;
  logic [2:0]  used1;

  seq_wide_comparator_ctrl #(.W(16), .N(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0),
    .busy(busy0), .done(done0), .great(great0), .less(less0),
    .equal(equal0), .slices_used(used0)
  );

  seq_wide_comparator_ctrl #(.W(32), .N(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .great(great1), .less(less1),
    .equal(equal1), .slices_used(used1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slices examined = position of the first differing slice from the MSB, plus one.
  function automatic int ref_used(input logic [31:0] x, input int w, input int n);
    int p;
    p = -1;
    for (int i = 0; i < w; i++) if (x[i]) p = i;
    if (p < 0) return w / n;
    return (w - 1 - p) / n + 1;
  endfunction

  function automatic void gen(input int w, input int n, output logic [31:0] x, output logic [31:0] y);
    logic [31:0] mask;
    int mode, k;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x = $urandom & mask;
    mode = $urandom_range(0, 3);
    case (mode)
      0: y = $urandom & mask;
      1: y = x;
      2: begin
        k = $urandom_range(0, w / n - 1);
        y = x ^ (32'($urandom_range(1, (1 << n) - 1)) << (k * n));
      end
      default: y = x ^ (32'd1 << $urandom_range(0, w - 1));
    endcase
  endfunction

  task automatic check_idle0(input string tag);
    check({tag, ".busy"}, 32'(busy0), 32'd0);
    check({tag, ".done"}, 32'(done0), 32'd0);
    check({tag, ".great"}, 32'(great0), 32'd0);
    check({tag, ".less"}, 32'(less0), 32'd0);
    check({tag, ".equal"}, 32'(equal0), 32'd0);
    check({tag, ".used"}, 32'(used0), 32'd0);
  endtask

  task automatic run0(input logic [15:0] a, input logic [15:0] b, input string tag);
    int k, eu;
    eu = ref_used(32'(a ^ b), 16, 4);
    @(negedge clk); a0 = a; b0 = b; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    check({tag, ".busy"}, 32'(busy0), 32'd1);
    check({tag, ".clr"}, 32'({great0, less0, equal0}), 32'd0);
    k = 0;
    while (!done0 && k < 20) begin @(negedge clk); k++; end
    check({tag, ".lat"}, 32'(k), 32'(eu));
    check({tag, ".great"}, 32'(great0), 32'(a > b));
    check({tag, ".less"}, 32'(less0), 32'(a < b));
    check({tag, ".equal"}, 32'(equal0), 32'(a == b));
    check({tag, ".used"}, 32'(used0), 32'(eu));
    @(negedge clk);
    check({tag, ".pulse"}, 32'({busy0, done0}), 32'd0);
  endtask

  initial begin
    int k, lat0, lat1, eu0, eu1, dcount;
    logic seen0, seen1;
    logic [31:0] x0, y0, x1, y1;

    #12;
    check_idle0("rst_hold");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check_idle0("rst_rel");

    run0(16'hA000, 16'h5FFF, "t1");
    run0(16'h1234, 16'h1239, "t2");
    run0(16'hBEEF, 16'hBEEF, "t3");
    repeat (10) @(negedge clk);
    check("t3.hold_eq", 32'(equal0), 32'd1);
    check("t3.hold_used", 32'(used0), 32'd4);

    // Second start during CMP with a changed is ignored; a held start re-arms after DONE.
    @(negedge clk); a0 = 16'h12F0; b0 = 16'h1200; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); a0 = 16'h0000; start0 = 1'b1;
    @(negedge clk); check("t4.nodone", 32'(done0), 32'd0);
    @(negedge clk);
    check("t4.done", 32'(done0), 32'd1);
    check("t4.great", 32'(great0), 32'd1);
    check("t4.used", 32'(used0), 32'd3);
    @(negedge clk);
    check("t4.idle", 32'(busy0), 32'd0);
    check("t4.held", 32'(great0), 32'd1);
    @(negedge clk); start0 = 1'b0;
    check("t4.reacc", 32'(busy0), 32'd1);
    check("t4.clr", 32'(great0), 32'd0);
    @(negedge clk);
    check("t4.done2", 32'(done0), 32'd1);
    check("t4.less2", 32'(less0), 32'd1);
    check("t4.used2", 32'(used0), 32'd1);
    @(negedge clk);

    // Reset during the second CMP cycle aborts without a done pulse.
    @(negedge clk); a0 = 16'h0001; b0 = 16'h0002; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    check_idle0("t5.abort");
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (6) begin @(negedge clk); if (done0) dcount++; end
    check("t5.nopulse", 32'(dcount), 32'd0);
    run0(16'h0001, 16'h0002, "t5.fresh");

    for (int it = 0; it < 5000; it++) begin
      gen(16, 4, x0, y0);
      gen(32, 8, x1, y1);
      eu0 = ref_used(x0 ^ y0, 16, 4);
      eu1 = ref_used(x1 ^ y1, 32, 8);
      a0 = x0[15:0]; b0 = y0[15:0]; start0 = 1'b1;
      a1 = x1; b1 = y1; start1 = 1'b1;
      @(negedge clk); start0 = 1'b0; start1 = 1'b0;
      a0 = 16'($urandom); b0 = 16'($urandom); a1 = $urandom; b1 = $urandom;
      k = 0; seen0 = 1'b0; seen1 = 1'b0; lat0 = 99; lat1 = 99;
      while (!(seen0 && seen1) && k < 12) begin
        @(negedge clk); k++;
        if (!seen0 && done0) begin
          seen0 = 1'b1; lat0 = k;
          check("r16.result", 32'({great0, less0, equal0}), 32'({x0 > y0, x0 < y0, x0 == y0}));
          check("r16.used", 32'(used0), 32'(eu0));
        end
        if (!seen1 && done1) begin
          seen1 = 1'b1; lat1 = k;
          check("r32.result", 32'({great1, less1, equal1}), 32'({x1 > y1, x1 < y1, x1 == y1}));
          check("r32.used", 32'(used1), 32'(eu1));
        end
      end
      check("r16.lat", 32'(lat0), 32'(eu0));
      check("r32.lat", 32'(lat1), 32'(eu1));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
